// File: rtl/corner_box_tracker.sv
// corner_box_tracker
//   Builds a per-frame bounding box around the corners reported by a Harris
//   corner stage. It publishes that box, its centre and the corner count once
//   per frame. A frame boundary is a falling edge of VGA_VS.
//   A box is published only when a frame holds at least MIN_COUNT corners.
//   Short frames leave the last good box in place. After HOLD_FRAMES short
//   frames in a row, the box is withdrawn.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   VGA_VS           vertical sync, active low
//   corner_detected  corner strobe; qualifies addr_corner_x/addr_corner_y
//   addr_corner_x/y  corner column/row (10-bit unsigned)
//   box_*            published bounding box
//   center_x/y       published box centre
//   corner_count     accepted corners in the last completed frame
//   box_valid        published box is current or inside the hold window
//   frame_done       one-cycle pulse on each publish
module corner_box_tracker #(
  parameter int MIN_COUNT   = 4,
  parameter int HOLD_FRAMES = 3,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_VS,
  input  logic        corner_detected,
  input  logic [9:0]  addr_corner_x,
  input  logic [9:0]  addr_corner_y,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
  output logic [9:0]  box_y_max,
  output logic [9:0]  center_x,
  output logic [9:0]  center_y,
  output logic [15:0] corner_count,
  output logic        box_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {WAIT_SYNC, ACCUM, PUBLISH} state_t;

  typedef struct packed {
    logic [9:0]  x_min;
    logic [9:0]  x_max;
    logic [9:0]  y_min;
    logic [9:0]  y_max;
    logic [15:0] count;
  } acc_t;

  localparam acc_t ACC_CLEAR = '{x_min: 10'h3FF, x_max: 10'h000,
                                 y_min: 10'h3FF, y_max: 10'h000,
                                 count: 16'h0000};

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [15:0] MIN_CNT = 16'(MIN_COUNT);
  localparam int          MW      = $clog2(HOLD_FRAMES + 2);
  localparam logic [MW-1:0] HOLD_LIM = MW'(HOLD_FRAMES);

  state_t        state_q, state_d;
  logic          vs_q;
  acc_t          acc_q, acc_d;
  acc_t          snap_q, snap_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [39:0]   box_q, box_d;      // {x_min, x_max, y_min, y_max}
  logic [19:0]   center_q, center_d; // {center_x, center_y}
  logic [15:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          fb;
  logic          accept;
  acc_t          acc_step;
  logic [10:0]   sum_x, sum_y;
  logic [MW-1:0] miss_inc;

  function automatic acc_t add_corner(input acc_t a, input logic [9:0] x,
                                      input logic [9:0] y);
    acc_t r;
    r       = a;
    r.x_min = (x < a.x_min) ? x : a.x_min;
    r.x_max = (x > a.x_max) ? x : a.x_max;
    r.y_min = (y < a.y_min) ? y : a.y_min;
    r.y_max = (y > a.y_max) ? y : a.y_max;
    r.count = (a.count == 16'hFFFF) ? a.count : a.count + 16'd1;
    return r;
  endfunction

  assign fb     = vs_q & ~VGA_VS;
  assign accept = corner_detected &&
                  ({1'b0, addr_corner_x} < H_LIM) &&
                  ({1'b0, addr_corner_y} < V_LIM);
  assign sum_x  = {1'b0, snap_q.x_min} + {1'b0, snap_q.x_max};
  assign sum_y  = {1'b0, snap_q.y_min} + {1'b0, snap_q.y_max};

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    acc_d    = acc_q;
    snap_d   = snap_q;
    miss_d   = miss_q;
    box_d    = box_q;
    center_d = center_q;
    count_d  = count_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    miss_inc = (miss_q < HOLD_LIM) ? miss_q + MW'(1) : miss_q;
    acc_step = add_corner(acc_q, addr_corner_x, addr_corner_y);

    case (state_q)
      WAIT_SYNC: begin
        acc_d = ACC_CLEAR;
        if (fb) state_d = ACCUM;
      end
      ACCUM: begin
        if (fb) begin
          // Close the frame. A corner that arrives on the boundary cycle
          // belongs to the frame that is opening.
          snap_d  = acc_q;
          acc_d   = accept ? add_corner(ACC_CLEAR, addr_corner_x, addr_corner_y)
                           : ACC_CLEAR;
          state_d = PUBLISH;
        end else if (accept) begin
          acc_d = acc_step;
        end
      end
      PUBLISH: begin
        if (accept) acc_d = acc_step;
        state_d = ACCUM;
        done_d  = 1'b1;
        count_d = snap_q.count;
        if (snap_q.count >= MIN_CNT) begin
          box_d    = {snap_q.x_min, snap_q.x_max, snap_q.y_min, snap_q.y_max};
          center_d = {sum_x[10:1], sum_y[10:1]};
          valid_d  = 1'b1;
          miss_d   = '0;
        end else begin
          miss_d = miss_inc;
          if (miss_inc == HOLD_LIM) begin
            box_d    = '0;
            center_d = '0;
            valid_d  = 1'b0;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_SYNC;
      vs_q     <= 1'b1;
      acc_q    <= ACC_CLEAR;
      snap_q   <= ACC_CLEAR;
      miss_q   <= '0;
      box_q    <= '0;
      center_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the order of the statements below does not matter.
      state_q  <= state_d;
      vs_q     <= VGA_VS;
      acc_q    <= acc_d;
      snap_q   <= snap_d;
      miss_q   <= miss_d;
      box_q    <= box_d;
      center_q <= center_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign {box_x_min, box_x_max, box_y_min, box_y_max} = box_q;
  assign {center_x, center_y} = center_q;
  assign corner_count = count_q;
  assign box_valid    = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_corner_box_tracker.sv
// Directed bench for corner_box_tracker. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed values.
module tb_corner_box_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        VGA_VS;
  logic        corner_detected;
  logic [9:0]  addr_corner_x;
  logic [9:0]  addr_corner_y;
  logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
  logic [9:0]  center_x, center_y;
  logic [15:0] corner_count;
  logic        box_valid;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // {x_min, x_max, y_min, y_max, center_x, center_y}
  logic [59:0] box_vec;
  assign box_vec = {box_x_min, box_x_max, box_y_min, box_y_max, center_x, center_y};

  corner_box_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .VGA_VS          (VGA_VS),
    .corner_detected (corner_detected),
    .addr_corner_x   (addr_corner_x),
    .addr_corner_y   (addr_corner_y),
    .box_x_min       (box_x_min),
    .box_x_max       (box_x_max),
    .box_y_min       (box_y_min),
    .box_y_max       (box_y_max),
    .center_x        (center_x),
    .center_y        (center_y),
    .corner_count    (corner_count),
    .box_valid       (box_valid),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic corner(input int cx, input int cy);
    corner_detected = 1'b1;
    addr_corner_x   = 10'(cx);
    addr_corner_y   = 10'(cy);
    tick();
    corner_detected = 1'b0;
  endtask

  // Returns just after the edge that samples the frame boundary.
  task automatic frame_sync;
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; VGA_VS = 1'b1; corner_detected = 1'b0;
    addr_corner_x = '0; addr_corner_y = '0;
    repeat (3) tick();
    checks++;
    if (box_vec !== 60'd0) begin
      errors++; $display("FAIL reset_box got %h want 0", box_vec);
    end
    checks++;
    if ({corner_count, box_valid, frame_done} !== 18'd0) begin
      errors++; $display("FAIL reset_flags got cnt=%0d valid=%b done=%b want 0/0/0",
                         corner_count, box_valid, frame_done);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_first_frame;
    // Ignored: the tracker is still waiting for the first boundary.
    corner(1, 1); corner(2, 2); corner(3, 3); corner(4, 4);
    frame_sync();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++; $display("FAIL first_fb_no_publish cycle %0d got %b want 0", i, frame_done);
      end
    end
    corner(100, 50); corner(200, 50); corner(100, 150); corner(200, 150);
    frame_sync();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL publish_latency got %b want 0", frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL first_done got %b want 1", frame_done);
    end
    checks++;
    if (box_vec !== {10'd100, 10'd200, 10'd50, 10'd150, 10'd150, 10'd100}) begin
      errors++; $display("FAIL first_box got %h want box 100/200/50/150 ctr 150/100", box_vec);
    end
    checks++;
    if (corner_count !== 16'd4 || box_valid !== 1'b1) begin
      errors++; $display("FAIL first_cnt got cnt=%0d valid=%b want 4/1", corner_count, box_valid);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || box_vec !== {10'd100, 10'd200, 10'd50, 10'd150, 10'd150, 10'd100}) begin
      errors++; $display("FAIL first_after got done=%b box=%h want 0 and held box", frame_done, box_vec);
    end
  endtask

  task automatic test_hold;
    for (int f = 1; f <= 3; f++) begin
      corner(300, 300); corner(310, 310);
      frame_sync();
      tick();
      checks++;
      if (corner_count !== 16'd2 || frame_done !== 1'b1) begin
        errors++; $display("FAIL hold_cnt frame %0d got cnt=%0d done=%b want 2/1", f, corner_count, frame_done);
      end
      if (f < 3) begin
        checks++;
        if (box_valid !== 1'b1 || box_vec !== {10'd100, 10'd200, 10'd50, 10'd150, 10'd150, 10'd100}) begin
          errors++; $display("FAIL hold_box frame %0d got valid=%b box=%h want held box", f, box_valid, box_vec);
        end
      end else begin
        checks++;
        if (box_valid !== 1'b0 || box_vec !== 60'd0) begin
          errors++; $display("FAIL hold_drop got valid=%b box=%h want 0/0", box_valid, box_vec);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    corner(640, 10); corner(10, 480); corner(1023, 1023);
    corner(20, 30); corner(40, 30); corner(20, 60); corner(40, 60);
    frame_sync();
    tick();
    checks++;
    if (corner_count !== 16'd4 || box_valid !== 1'b1) begin
      errors++; $display("FAIL range_cnt got cnt=%0d valid=%b want 4/1", corner_count, box_valid);
    end
    checks++;
    if (box_vec !== {10'd20, 10'd40, 10'd30, 10'd60, 10'd30, 10'd45}) begin
      errors++; $display("FAIL range_box got %h want box 20/40/30/60 ctr 30/45", box_vec);
    end
  endtask

  task automatic test_fb_corner;
    corner(50, 50); corner(60, 60); corner(70, 70); corner(80, 80);
    // Boundary and corner (5,5) on the same edge.
    VGA_VS = 1'b0; corner_detected = 1'b1; addr_corner_x = 10'd5; addr_corner_y = 10'd5;
    tick();
    corner_detected = 1'b0; VGA_VS = 1'b1;
    // This corner lands in the publish cycle and must still be accumulated.
    corner(90, 90);
    checks++;
    if (frame_done !== 1'b1 || corner_count !== 16'd4) begin
      errors++; $display("FAIL fbc_close got done=%b cnt=%0d want 1/4", frame_done, corner_count);
    end
    checks++;
    if (box_vec !== {10'd50, 10'd80, 10'd50, 10'd80, 10'd65, 10'd65}) begin
      errors++; $display("FAIL fbc_close_box got %h want box 50/80/50/80 ctr 65/65", box_vec);
    end
    corner(95, 95); corner(99, 99);
    frame_sync();
    tick();
    checks++;
    if (corner_count !== 16'd4 || box_valid !== 1'b1) begin
      errors++; $display("FAIL fbc_next_cnt got cnt=%0d valid=%b want 4/1", corner_count, box_valid);
    end
    checks++;
    if (box_vec !== {10'd5, 10'd99, 10'd5, 10'd99, 10'd52, 10'd52}) begin
      errors++; $display("FAIL fbc_next_box got %h want box 5/99/5/99 ctr 52/52", box_vec);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 10; i++) corner(i * 10 + 10, i * 5 + 10);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (box_vec !== 60'd0 || corner_count !== 16'd0 || box_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL async_reset got box=%h cnt=%0d valid=%b done=%b want all 0",
                         box_vec, corner_count, box_valid, frame_done);
    end
    tick();
    reset = 1'b1;
    frame_sync();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0 || corner_count !== 16'd0) begin
        errors++; $display("FAIL post_reset_fb cycle %0d got done=%b cnt=%0d want 0/0", i, frame_done, corner_count);
      end
    end
    corner(7, 8); corner(9, 8); corner(7, 12); corner(9, 12);
    frame_sync();
    tick();
    checks++;
    if (frame_done !== 1'b1 || corner_count !== 16'd4 || box_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_pub got done=%b cnt=%0d valid=%b want 1/4/1",
                         frame_done, corner_count, box_valid);
    end
    checks++;
    if (box_vec !== {10'd7, 10'd9, 10'd8, 10'd12, 10'd8, 10'd10}) begin
      errors++; $display("FAIL post_reset_box got %h want box 7/9/8/12 ctr 8/10", box_vec);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hold();
    test_out_of_range();
    test_fb_corner();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
